// File: rtl/cpu_controller.sv
// Control FSM for a small load/store-free CPU: holds the instruction register,
// decodes it and sequences the register file, A/B/C registers and ALU.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   s, load, in     - start pulse, instruction capture strobe, instruction word
//   w               - high while idle in WAIT
//   readnum         - register-file read address
//   writenum        - register-file write address
//   write           - register-file write enable
//   loada, loadb    - A / B operand register loads
//   loadc, loads    - C result register load, status (Z,N,V) load
//   asel            - forces the ALU A operand to zero
//   bsel            - selects sximm5 as the B operand
//   vsel            - writeback source (00 = C, 10 = sximm8)
//   ALU_op, shift   - ALU operation and B shifter code
//   sximm8, sximm5  - sign-extended immediates taken from ir
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALU_op,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    // Instruction fields
    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    // Instruction classes
    logic w_is_mov_imm;
    logic w_is_mov_reg;
    logic w_is_add;
    logic w_is_cmp;
    logic w_is_and;
    logic w_is_mvn;

    assign w_is_mov_imm = (w_opcode == OPC_MOV) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opcode == OPC_MOV) && (w_op == 2'b00);
    assign w_is_add     = (w_opcode == OPC_ALU) && (w_op == 2'b00);
    assign w_is_cmp     = (w_opcode == OPC_ALU) && (w_op == 2'b01);
    assign w_is_and     = (w_opcode == OPC_ALU) && (w_op == 2'b10);
    assign w_is_mvn     = (w_opcode == OPC_ALU) && (w_op == 2'b11);

    // Two-operand ops fetch Rn first; single-operand ops go straight to Rm
    logic w_needs_a;
    logic w_needs_b_only;

    assign w_needs_a      = w_is_add | w_is_cmp | w_is_and;
    assign w_needs_b_only = w_is_mov_reg | w_is_mvn;

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

    // State and instruction register. ir only changes in WAIT so it stays
    // stable across the whole instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT) && load) begin
                r_ir <= in;
            end
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_next   = S_WAIT;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        ALU_op   = 2'b00;
        shift    = 2'b00;

        unique case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_WAIT;
                end
            end

            S_DECODE: begin
                if (w_is_mov_imm) begin
                    w_next = S_WR_IMM;
                end else if (w_needs_a) begin
                    w_next = S_GET_A;
                end else if (w_needs_b_only) begin
                    w_next = S_GET_B;
                end else begin
                    w_next = S_WAIT;
                end
            end

            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = S_GET_B;
            end

            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_EXEC;
            end

            S_EXEC: begin
                shift = w_sh;
                bsel  = 1'b0;
                // MOV reg passes the shifted B through as 0 + B
                if (w_is_mov_reg) begin
                    ALU_op = 2'b00;
                    asel   = 1'b1;
                end else begin
                    ALU_op = w_op;
                end
                // CMP only updates status; nothing is written back
                if (w_is_cmp) begin
                    loads  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WR_REG;
                end
            end

            S_WR_REG: begin
                writenum = w_rd;
                vsel     = 2'b00;
                write    = 1'b1;
                w_next   = S_WAIT;
            end

            S_WR_IMM: begin
                writenum = w_rn;
                vsel     = 2'b10;
                write    = 1'b1;
                w_next   = S_WAIT;
            end

            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle expected output snapshots are
// queued as each instruction is started and popped/compared every cycle.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALU_op;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load     (load),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .ALU_op   (ALU_op),
        .shift    (shift),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] rn;
        logic [2:0] wn;
        logic       wr;
        logic       la;
        logic       lb;
        logic       lc;
        logic       ls;
        logic       as;
        logic       bs;
        logic [1:0] vs;
        logic [1:0] op;
        logic [1:0] sh;
    } outs_t;

    outs_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    wr_cnt = 0;
    int    wr_base;
    bit    jam = 1'b0;

    always @(negedge clk) begin
        if (write === 1'b1) wr_cnt++;
    end

    function automatic outs_t e_wait();
        outs_t e;
        e = '0;
        e.w = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_dec();
        outs_t e;
        e = '0;
        return e;
    endfunction

    function automatic outs_t e_geta(logic [2:0] rn);
        outs_t e;
        e = '0;
        e.rn = rn;
        e.la = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_getb(logic [2:0] rn);
        outs_t e;
        e = '0;
        e.rn = rn;
        e.lb = 1'b1;
        return e;
    endfunction

    function automatic outs_t e_exec(logic [1:0] op, logic [1:0] sh,
                                     logic as, logic lc, logic ls);
        outs_t e;
        e = '0;
        e.op = op;
        e.sh = sh;
        e.as = as;
        e.lc = lc;
        e.ls = ls;
        return e;
    endfunction

    function automatic outs_t e_wr(logic [2:0] wn, logic [1:0] vs);
        outs_t e;
        e = '0;
        e.wn = wn;
        e.vs = vs;
        e.wr = 1'b1;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input outs_t e);
        outs_t o;
        o = '{w, readnum, writenum, write, loada, loadb, loadc, loads,
              asel, bsel, vsel, ALU_op, shift};
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: outputs got %05h want %05h", tag, o, e);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] o,
                         input logic [15:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: got %04h want %04h", tag, o, e);
        end
    endtask

    task automatic chk_wr(input string tag, input int e);
        n_cmp++;
        assert ((wr_cnt - wr_base) == e) else begin
            n_err++;
            $error("FAIL %s: write cycles got %0d want %0d",
                   tag, wr_cnt - wr_base, e);
        end
    endtask

    task automatic load_ir(input logic [15:0] x);
        load = 1'b1;
        in   = x;
        step();
        load = 1'b0;
        in   = 16'h0000;
    endtask

    task automatic start();
        wr_base = wr_cnt;
        s = 1'b1;
        step();
        s = 1'b0;
    endtask

    // Pop one snapshot per cycle; optionally hammer load/in/s while busy
    task automatic drain(input string tag);
        outs_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(tag, e);
            if (q.size() > 0) begin
                if (jam) begin
                    load = 1'b1;
                    in   = 16'($urandom);
                    s    = 1'($urandom);
                end
                step();
            end
        end
        load = 1'b0;
        s    = 1'b0;
        in   = 16'h0000;
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("reset", e_wait());
        chk16("reset_sximm8", sximm8, 16'h0000);
        chk16("reset_sximm5", sximm5, 16'h0000);

        // MOV R0,#-5
        load_ir(16'hD0FB);
        chk16("movi_sximm8", sximm8, 16'hFFFB);
        chk16("movi_sximm5", sximm5, 16'hFFFB);
        start();
        q.push_back(e_dec());
        q.push_back(e_wr(3'd0, 2'b10));
        q.push_back(e_wait());
        drain("movi");
        chk_wr("movi_wr", 1);

        // ADD R2,R1,R0 LSL#1
        load_ir(16'hA148);
        start();
        q.push_back(e_dec());
        q.push_back(e_geta(3'd1));
        q.push_back(e_getb(3'd0));
        q.push_back(e_exec(2'b00, 2'b01, 1'b0, 1'b1, 1'b0));
        q.push_back(e_wr(3'd2, 2'b00));
        q.push_back(e_wait());
        drain("add");
        chk_wr("add_wr", 1);

        // CMP R1,R2
        load_ir(16'hA902);
        start();
        q.push_back(e_dec());
        q.push_back(e_geta(3'd1));
        q.push_back(e_getb(3'd2));
        q.push_back(e_exec(2'b01, 2'b00, 1'b0, 1'b0, 1'b1));
        q.push_back(e_wait());
        drain("cmp");
        chk_wr("cmp_wr", 0);

        // MVN R3,R4
        load_ir(16'hB864);
        start();
        q.push_back(e_dec());
        q.push_back(e_getb(3'd4));
        q.push_back(e_exec(2'b11, 2'b00, 1'b0, 1'b1, 1'b0));
        q.push_back(e_wr(3'd3, 2'b00));
        q.push_back(e_wait());
        drain("mvn");
        chk_wr("mvn_wr", 1);

        // AND R7,R5,R3 ASR (Rn=5 Rd=7 sh=11 Rm=3)
        load_ir(16'hB5FB);
        start();
        q.push_back(e_dec());
        q.push_back(e_geta(3'd5));
        q.push_back(e_getb(3'd3));
        q.push_back(e_exec(2'b10, 2'b11, 1'b0, 1'b1, 1'b0));
        q.push_back(e_wr(3'd7, 2'b00));
        q.push_back(e_wait());
        drain("and");
        chk_wr("and_wr", 1);

        // MOV R5,R6 LSR (Rd=5 sh=10 Rm=6)
        load_ir(16'hC0B6);
        start();
        q.push_back(e_dec());
        q.push_back(e_getb(3'd6));
        q.push_back(e_exec(2'b00, 2'b10, 1'b1, 1'b1, 1'b0));
        q.push_back(e_wr(3'd5, 2'b00));
        q.push_back(e_wait());
        drain("movr");
        chk_wr("movr_wr", 1);

        // Undefined encodings
        load_ir(16'h0000);
        start();
        q.push_back(e_dec());
        q.push_back(e_wait());
        drain("undef0");
        chk_wr("undef0_wr", 0);

        load_ir(16'hC8FF);
        start();
        q.push_back(e_dec());
        q.push_back(e_wait());
        drain("undef1");
        chk_wr("undef1_wr", 0);

        // ADD with load/in/s toggling while busy: ir must hold
        load_ir(16'hA148);
        start();
        jam = 1'b1;
        q.push_back(e_dec());
        q.push_back(e_geta(3'd1));
        q.push_back(e_getb(3'd0));
        q.push_back(e_exec(2'b00, 2'b01, 1'b0, 1'b1, 1'b0));
        q.push_back(e_wr(3'd2, 2'b00));
        q.push_back(e_wait());
        drain("add_jam");
        jam = 1'b0;
        chk_wr("add_jam_wr", 1);
        chk16("add_jam_sximm8", sximm8, 16'h0048);
        chk16("add_jam_sximm5", sximm5, 16'h0008);

        // Reset during GET_B aborts with no write
        load_ir(16'hA148);
        start();
        q.push_back(e_dec());
        q.push_back(e_geta(3'd1));
        q.push_back(e_getb(3'd0));
        drain("abort_pre");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_wait", e_wait());
        chk16("abort_sximm8", sximm8, 16'h0000);
        step();
        step();
        step();
        chk("abort_idle", e_wait());
        chk_wr("abort_wr", 0);

        // Load and start in the same WAIT cycle
        load = 1'b1;
        in   = 16'hD3FF;
        wr_base = wr_cnt;
        s    = 1'b1;
        step();
        load = 1'b0;
        s    = 1'b0;
        q.push_back(e_dec());
        q.push_back(e_wr(3'd3, 2'b10));
        q.push_back(e_wait());
        drain("movi_same");
        chk16("movi_same_sximm8", sximm8, 16'hFFFF);
        chk_wr("movi_same_wr", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
